// File: rtl/fp_round_pkg.sv
// Shared rounding-mode encoding and default widths for the round-and-pack pipeline.
package fp_round_pkg;

    localparam int EXP_W_DEF = 3;
    localparam int MAN_W_DEF = 4;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        RND_TRUNC     = 2'd0,
        RND_HALF_UP   = 2'd1,
        RND_NEAR_EVEN = 2'd2,
        RND_RSVD      = 2'd3
    } rnd_mode_e;

endpackage

// File: rtl/fp_round_inc.sv
// Rounding datapath: the increment/add half feeds stage 1, and the
// renormalise/saturate half consumes the stage 1 registers to feed stage 2.
module fp_round_inc
    import fp_round_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic [MAN_W-1:0] man,
    input  logic             guard,
    input  logic             sticky,
    input  logic [1:0]       mode,
    output logic [MAN_W:0]   sum,
    input  logic [EXP_W-1:0] s1_exp,
    input  logic [MAN_W:0]   s1_sum,
    output logic [EXP_W-1:0] res_exp,
    output logic [MAN_W-1:0] res_man,
    output logic             res_sat
);

    rnd_mode_e mode_s;
    logic      inc_s;

    assign mode_s = rnd_mode_e'(mode);

    // Increment decision for the selected mode; the reserved code truncates.
    always_comb begin
        inc_s = 1'b0;
        case (mode_s)
            RND_TRUNC:     inc_s = 1'b0;
            RND_HALF_UP:   inc_s = guard;
            RND_NEAR_EVEN: inc_s = guard & (sticky | man[0]);
            RND_RSVD:      inc_s = 1'b0;
            default:       inc_s = 1'b0;
        endcase
    end

    assign sum = {1'b0, man} + {{MAN_W{1'b0}}, inc_s};

    // Carry-out either bumps the exponent (significand becomes 100..0) or clamps.
    always_comb begin
        res_exp = s1_exp;
        res_man = s1_sum[MAN_W-1:0];
        res_sat = 1'b0;
        if (!s1_sum[MAN_W]) begin
            res_exp = s1_exp;
            res_man = s1_sum[MAN_W-1:0];
            res_sat = 1'b0;
        end else if (s1_exp != {EXP_W{1'b1}}) begin
            res_exp = s1_exp + EXP_W'(1);
            res_man = s1_sum[MAN_W:1];
            res_sat = 1'b0;
        end else begin
            res_exp = {EXP_W{1'b1}};
            res_man = {MAN_W{1'b1}};
            res_sat = 1'b1;
        end
    end

endmodule

// File: rtl/fp_round_pipe.sv
// Two-stage round-and-pack pipeline with valid/ready on both sides and a
// saturating count of delivered clamped results.
module fp_round_pipe
    import fp_round_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [MAN_W-1:0] in_man,
    input  logic             in_guard,
    input  logic             in_sticky,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [MAN_W-1:0] out_man,
    output logic             out_sat,
    output logic             out_inexact,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] sat_count
);

    logic             s1_valid_r;
    logic             s1_sign_r;
    logic             s1_inexact_r;
    logic [EXP_W-1:0] s1_exp_r;
    logic [MAN_W:0]   s1_sum_r;

    logic             s1_adv_s;
    logic             s2_adv_s;
    logic [MAN_W:0]   sum_s;
    logic [EXP_W-1:0] res_exp_s;
    logic [MAN_W-1:0] res_man_s;
    logic             res_sat_s;

    assign s2_adv_s = !out_valid || out_ready;
    assign s1_adv_s = !s1_valid_r || s2_adv_s;
    assign in_ready = s1_adv_s;

    fp_round_inc #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_inc (
        .man     (in_man),
        .guard   (in_guard),
        .sticky  (in_sticky),
        .mode    (in_mode),
        .sum     (sum_s),
        .s1_exp  (s1_exp_r),
        .s1_sum  (s1_sum_r),
        .res_exp (res_exp_s),
        .res_man (res_man_s),
        .res_sat (res_sat_s)
    );

    // Stage 1: capture sign, exponent, rounded sum and inexact flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r   <= 1'b0;
            s1_sign_r    <= 1'b0;
            s1_inexact_r <= 1'b0;
            s1_exp_r     <= {EXP_W{1'b0}};
            s1_sum_r     <= {(MAN_W+1){1'b0}};
        end else if (s1_adv_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_sign_r    <= in_sign;
                s1_inexact_r <= in_guard | in_sticky;
                s1_exp_r     <= in_exp;
                s1_sum_r     <= sum_s;
            end
        end
    end

    // Stage 2: registered result; held untouched while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_sign    <= 1'b0;
            out_exp     <= {EXP_W{1'b0}};
            out_man     <= {MAN_W{1'b0}};
            out_sat     <= 1'b0;
            out_inexact <= 1'b0;
        end else if (s2_adv_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                out_sign    <= s1_sign_r;
                out_exp     <= res_exp_s;
                out_man     <= res_man_s;
                out_sat     <= res_sat_s;
                out_inexact <= s1_inexact_r;
            end
        end
    end

    // Saturation event counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            sat_count <= {CNT_W{1'b0}};
        end else if (out_valid && out_ready && out_sat && (sat_count != {CNT_W{1'b1}})) begin
            sat_count <= sat_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fp_round_pipe.sv
// Scoreboard bench for fp_round_pipe: expected results come from an integer
// reference model and are checked by an independent output monitor.
module tb_fp_round_pipe;
    import fp_round_pkg::*;

    localparam int EXP_W   = 3;
    localparam int MAN_W   = 4;
    localparam int CNT_W   = 2;
    localparam int EXP_MAX = (1 << EXP_W) - 1;
    localparam int MAN_LIM = 1 << MAN_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        int sign;
        int exp;
        int man;
        int sat;
        int inexact;
        int cyc;
        bit chk_lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_sign = 1'b0;
    logic [EXP_W-1:0] in_exp = '0;
    logic [MAN_W-1:0] in_man = '0;
    logic             in_guard = 1'b0;
    logic             in_sticky = 1'b0;
    logic [1:0]       in_mode = 2'd0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_sign;
    logic [EXP_W-1:0] out_exp;
    logic [MAN_W-1:0] out_man;
    logic             out_sat;
    logic             out_inexact;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] sat_count;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   satm = 0;
    int   bp_mode = 0;
    int   bp_start = 0;
    bit   no_bp = 1'b1;
    bit   saw_block = 1'b0;
    bit   held_v = 1'b0;
    int   held = 0;
    exp_t q[$];

    fp_round_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man),
        .in_guard(in_guard), .in_sticky(in_sticky), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_man(out_man),
        .out_sat(out_sat), .out_inexact(out_inexact),
        .cnt_clr(cnt_clr), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Downstream ready pattern: 0 always ready, 1 random, 2 scripted stall, 3 stalled.
    always @(posedge clk) begin
        #2;
        case (bp_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            2: out_ready = !((cyc - bp_start) >= 2 && (cyc - bp_start) <= 5);
            3: out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: value-level rounding with plain integers.
    function automatic exp_t model(input int sg, input int e, input int m,
                                   input int g, input int s, input int mode);
        exp_t r;
        int   inc;
        int   total;
        if (mode == 1)      inc = g;
        else if (mode == 2) inc = (g != 0 && (s != 0 || (m % 2) == 1)) ? 1 : 0;
        else                inc = 0;
        total     = m + inc;
        r.sign    = sg;
        r.inexact = (g != 0 || s != 0) ? 1 : 0;
        r.sat     = 0;
        if (total < MAN_LIM) begin
            r.exp = e;
            r.man = total;
        end else if (e < EXP_MAX) begin
            r.exp = e + 1;
            r.man = total / 2;
        end else begin
            r.exp = EXP_MAX;
            r.man = MAN_LIM - 1;
            r.sat = 1;
        end
        r.cyc     = 0;
        r.chk_lat = 1'b0;
        return r;
    endfunction

    // Called right after a falling edge; returns right after the next one past acceptance.
    task automatic send(input int sg, input int e, input int m,
                        input int g, input int s, input int mode);
        exp_t r;
        int   waits = 0;
        in_valid  = 1'b1;
        in_sign   = sg[0];
        in_exp    = e[EXP_W-1:0];
        in_man    = m[MAN_W-1:0];
        in_guard  = g[0];
        in_sticky = s[0];
        in_mode   = mode[1:0];
        while (!in_ready && waits < 200) begin
            saw_block = 1'b1;
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
        end else begin
            r         = model(sg, e, m, g, s, mode);
            r.cyc     = cyc;
            r.chk_lat = no_bp;
            q.push_back(r);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: counter tracking, stall stability and in-order scoreboard compare.
    initial begin : monitor
        exp_t e;
        int   acc_sat;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                held_v = 1'b0;
                continue;
            end
            acc_sat = 0;
            check("sat_count", int'(sat_count), satm);
            if (held_v && out_valid)
                check("stall_stable", int'({out_sign, out_exp, out_man, out_sat, out_inexact}), held);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("out_sign", int'(out_sign), e.sign);
                    check("out_exp", int'(out_exp), e.exp);
                    check("out_man", int'(out_man), e.man);
                    check("out_sat", int'(out_sat), e.sat);
                    check("out_inexact", int'(out_inexact), e.inexact);
                    if (e.chk_lat) check("latency", cyc - e.cyc, 2);
                    acc_sat = e.sat;
                end
            end
            if (cnt_clr) satm = 0;
            else if (out_valid && out_ready && acc_sat != 0 && satm < CNT_MAX) satm++;
            held_v = out_valid && !out_ready;
            held   = int'({out_sign, out_exp, out_man, out_sat, out_inexact});
        end
    end

    task automatic drain();
        int b = 0;
        while (q.size() != 0 && b < 300) begin
            @(negedge clk);
            b++;
        end
        check("drain_empty", q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // {exp, man, guard, sticky, mode}
    int dir[12][5] = '{
        '{3, 10, 1, 0, 1}, '{5, 15, 1, 0, 1}, '{7, 15, 1, 0, 1},
        '{3, 10, 1, 0, 2}, '{3, 11, 1, 0, 2}, '{3, 10, 1, 1, 2},
        '{3, 10, 1, 0, 0}, '{3, 11, 1, 0, 0}, '{3, 10, 1, 1, 0},
        '{3, 10, 1, 0, 3}, '{3, 11, 1, 0, 3}, '{7, 15, 0, 0, 1}
    };

    initial begin : stimulus
        @(negedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_sat_count", int'(sat_count), 0);
        check("rst_out_data", int'({out_sign, out_exp, out_man, out_sat, out_inexact}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            send(i % 2, dir[i][0], dir[i][1], dir[i][2], dir[i][3], dir[i][4]);
            repeat (3) @(negedge clk);
        end
        drain();

        bp_start  = cyc;
        bp_mode   = 2;
        no_bp     = 1'b0;
        saw_block = 1'b0;
        for (int i = 0; i < 6; i++) send(0, i + 1, 8 + i, i % 2, 0, 1);
        check("in_ready_dropped", int'(saw_block), 1);
        drain();

        bp_mode = 1;
        for (int i = 0; i < 300; i++) begin
            send($urandom_range(0, 1), $urandom_range(0, EXP_MAX), $urandom_range(0, MAN_LIM - 1),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        bp_mode = 0;
        drain();

        cnt_clr = 1'b1;
        send(0, 7, 15, 1, 0, 1);
        repeat (4) @(negedge clk);
        cnt_clr = 1'b0;
        #1;
        check("clr_priority", int'(sat_count), 0);

        for (int i = 0; i < 5; i++) send(1, 7, 15, 1, 1, 2);
        drain();
        #1;
        check("sat_hold", int'(sat_count), CNT_MAX);

        @(negedge clk);
        bp_mode = 3;
        @(negedge clk);
        send(0, 2, 9, 1, 0, 1);
        send(0, 4, 12, 0, 1, 0);
        rst_n = 1'b0;
        q.delete();
        satm = 0;
        #1;
        check("async_rst_out_valid", int'(out_valid), 0);
        check("async_rst_sat_count", int'(sat_count), 0);
        @(negedge clk);
        rst_n   = 1'b1;
        bp_mode = 0;
        no_bp   = 1'b1;
        send(1, 6, 15, 1, 0, 1);
        send(0, 1, 3, 1, 1, 2);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
